// File: rtl/uart_req_sched_if.sv
// Request/command bundle between two requesters, the scheduler and the UART memory engine.
// The scheduler connects through the slave modport; the environment drives the master side.
interface uart_req_sched_if #(
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 8,
    parameter int IdWidth   = 4
);
    logic                 rd_req_valid_i;
    logic                 rd_req_ready_o;
    logic [AddrWidth-1:0] rd_req_addr_i;
    logic [LenWidth-1:0]  rd_req_len_i;
    logic [2:0]           rd_req_size_i;
    logic [IdWidth-1:0]   rd_req_id_i;

    logic                 wr_req_valid_i;
    logic                 wr_req_ready_o;
    logic [AddrWidth-1:0] wr_req_addr_i;
    logic [LenWidth-1:0]  wr_req_len_i;
    logic [2:0]           wr_req_size_i;
    logic [IdWidth-1:0]   wr_req_id_i;

    logic                 cmd_valid_o;
    logic                 cmd_ready_i;
    logic                 cmd_op_o;
    logic [AddrWidth-1:0] cmd_addr_o;
    logic [LenWidth-1:0]  cmd_len_o;
    logic [2:0]           cmd_size_o;
    logic [IdWidth-1:0]   cmd_id_o;

    logic                 rd_done_i;
    logic                 wr_done_i;
    logic                 busy_o;
    logic                 timeout_o;

    modport master (
        output rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_size_i, rd_req_id_i,
        output wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_size_i, wr_req_id_i,
        output cmd_ready_i, rd_done_i, wr_done_i,
        input  rd_req_ready_o, wr_req_ready_o,
        input  cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_id_o,
        input  busy_o, timeout_o
    );

    modport slave (
        input  rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_size_i, rd_req_id_i,
        input  wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_size_i, wr_req_id_i,
        input  cmd_ready_i, rd_done_i, wr_done_i,
        output rd_req_ready_o, wr_req_ready_o,
        output cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_id_o,
        output busy_o, timeout_o
    );
endinterface

// File: rtl/uart_req_sched.sv
// Round-robin read/write request scheduler with a single outstanding command and a
// WAIT_DONE watchdog that aborts a command whose completion never arrives.
module uart_req_sched #(
    parameter int AddrWidth     = 32,
    parameter int LenWidth      = 8,
    parameter int IdWidth       = 4,
    parameter int TimeoutCycles = 1048576
) (
    input  logic            clk_i,
    input  logic            reset_i,
    uart_req_sched_if.slave bus
);
    localparam int                CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_prio;
    logic                 r_cmd_op;
    logic [AddrWidth-1:0] r_cmd_addr;
    logic [LenWidth-1:0]  r_cmd_len;
    logic [2:0]           r_cmd_size;
    logic [IdWidth-1:0]   r_cmd_id;
    logic [CntWidth-1:0]  r_cnt;

    logic w_grant_rd;
    logic w_grant_wr;
    logic w_done_match;
    logic w_cnt_last;
    logic w_rd_ready;
    logic w_wr_ready;
    logic w_cmd_valid;
    logic w_timeout;
    logic w_finish;

    // r_prio breaks ties only; a lone requester always wins, and the two grants are exclusive.
    assign w_grant_rd   = bus.rd_req_valid_i && (!bus.wr_req_valid_i || !r_prio);
    assign w_grant_wr   = bus.wr_req_valid_i && (!bus.rd_req_valid_i ||  r_prio);
    assign w_done_match = r_cmd_op ? bus.wr_done_i : bus.rd_done_i;
    assign w_cnt_last   = (r_cnt == CntLast);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_ready   = 1'b0;
        w_wr_ready   = 1'b0;
        w_cmd_valid  = 1'b0;
        w_timeout    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            StIdle: begin
                w_rd_ready = w_grant_rd;
                w_wr_ready = w_grant_wr;
                if (w_grant_rd || w_grant_wr) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_cmd_valid = 1'b1;
                if (bus.cmd_ready_i) begin
                    w_state_next = StWaitDone;
                end
            end
            StWaitDone: begin
                // A matching done on the terminal count wins over the timeout.
                if (w_done_match) begin
                    w_finish     = 1'b1;
                    w_state_next = StIdle;
                end else if (w_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_finish     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_prio     <= 1'b0;
            r_cmd_op   <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_cmd_size <= '0;
            r_cmd_id   <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_rd_ready) begin
                r_cmd_op   <= 1'b0;
                r_cmd_addr <= bus.rd_req_addr_i;
                r_cmd_len  <= bus.rd_req_len_i;
                r_cmd_size <= bus.rd_req_size_i;
                r_cmd_id   <= bus.rd_req_id_i;
            end else if (w_wr_ready) begin
                r_cmd_op   <= 1'b1;
                r_cmd_addr <= bus.wr_req_addr_i;
                r_cmd_len  <= bus.wr_req_len_i;
                r_cmd_size <= bus.wr_req_size_i;
                r_cmd_id   <= bus.wr_req_id_i;
            end
            if (w_finish) begin
                r_prio <= ~r_cmd_op;
            end
            // Cleared on entry to WAIT_DONE, saturating so it can never wrap.
            if (r_state == StIssue && bus.cmd_ready_i) begin
                r_cnt <= '0;
            end else if (r_state == StWaitDone && !w_cnt_last) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    assign bus.rd_req_ready_o = w_rd_ready;
    assign bus.wr_req_ready_o = w_wr_ready;
    assign bus.cmd_valid_o    = w_cmd_valid;
    assign bus.cmd_op_o       = r_cmd_op;
    assign bus.cmd_addr_o     = r_cmd_addr;
    assign bus.cmd_len_o      = r_cmd_len;
    assign bus.cmd_size_o     = r_cmd_size;
    assign bus.cmd_id_o       = r_cmd_id;
    assign bus.busy_o         = (r_state != StIdle);
    assign bus.timeout_o      = w_timeout;
endmodule

// File: doc/uart_req_sched.md
UART_REQ_SCHED -- requirements
Module: uart_req_sched

Interface
REQ-001 SHALL have parameters: AddrWidth, default 32, address width; LenWidth, default 8, transfer-count width; IdWidth, default 4, request id width; TimeoutCycles, default 1048576, maximum WAIT_DONE cycles before abort.
REQ-002 SHALL have one clock; reset is asynchronous and active-high; the ports SHALL be named clk_i and reset_i.
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 reset_i  in  1  asynchronous active-high reset.
REQ-005 rd_req_valid_i / rd_req_ready_o  in/out  1  read request handshake.
REQ-006 rd_req_addr_i, rd_req_len_i, rd_req_size_i, rd_req_id_i  in  AddrWidth, LenWidth, 3, IdWidth  read request fields.
REQ-007 wr_req_valid_i / wr_req_ready_o  in/out  1  write request handshake.
REQ-008 wr_req_addr_i, wr_req_len_i, wr_req_size_i, wr_req_id_i  in  AddrWidth, LenWidth, 3, IdWidth  write request fields.
REQ-009 cmd_valid_o / cmd_ready_i  out/in  1  command handshake to the UART memory engine.
REQ-010 cmd_op_o  out  1  0 = read, 1 = write.
REQ-011 cmd_addr_o, cmd_len_o, cmd_size_o, cmd_id_o  out  AddrWidth, LenWidth, 3, IdWidth  registered command fields.
REQ-012 rd_done_i / wr_done_i  in  1  one-cycle pulses: read last beat accepted / write response accepted.
REQ-013 busy_o  out  1  high whenever state is not IDLE.
REQ-014 timeout_o  out  1  one-cycle pulse on WAIT_DONE abort.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_DONE; at most one transaction SHALL be outstanding.
REQ-016 IDLE: ready outputs SHALL be combinational; rd_req_ready_o = IDLE and read granted; wr_req_ready_o = IDLE and write granted; at most one ready SHALL be high per cycle.
REQ-017 Grant: only one requester valid -> that requester; both valid -> requester selected by prio_q (0 = read first, 1 = write first).
REQ-018 On grant, the accepted fields and op SHALL be captured into cmd_* registers and the state SHALL become ISSUE next cycle.
REQ-019 ISSUE: cmd_valid_o = 1; cmd_* SHALL remain stable until cmd_ready_i = 1, then the state SHALL become WAIT_DONE.
REQ-020 WAIT_DONE: only the done matching cmd_op_o SHALL end the transaction (-> IDLE); the non-matching done SHALL be ignored.
REQ-021 On normal completion, prio_q SHALL be set to the opposite of the served op (round-robin).
REQ-022 The timeout counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle; at count TimeoutCycles-1 with no matching done: timeout_o = 1 for one cycle, go to IDLE, flip prio_q as on completion.
REQ-023 A matching done in the timeout terminal cycle SHALL take precedence: normal completion, timeout_o stays 0.
REQ-024 The counter width SHALL be clog2(TimeoutCycles+1) and SHALL never wrap.
REQ-025 Done pulses in IDLE or ISSUE SHALL be ignored.
REQ-026 Completion and a new grant SHALL NOT occur in the same cycle; the earliest new ready is the cycle after return to IDLE.
REQ-027 The request-to-cmd_valid_o latency SHALL be exactly 1 cycle.

Reset
REQ-028 Reset SHALL force: state IDLE, prio_q 0, cmd_valid_o 0, cmd_op_o 0, cmd_addr_o/len/size/id 0, timeout counter 0, busy_o 0, timeout_o 0.
REQ-029 Reset during ISSUE or WAIT_DONE SHALL abandon the transaction with no timeout_o pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-030 Read only: rd valid, addr 0x1000, len 3, size 2, id 5 -> rd ready same cycle; next cycle cmd_valid=1, op 0, fields match; cmd_ready -> WAIT_DONE; rd_done -> IDLE, busy 0.
REQ-031 Both valid after reset -> read granted first; after rd_done, both still valid -> write granted next; after wr_done -> read granted.
REQ-032 cmd_ready held 0 for 5 cycles -> cmd_valid held 1 with stable fields, no ready to either requester.
REQ-033 Write outstanding, rd_done pulsed -> ignored, still busy; wr_done -> IDLE.
REQ-034 TimeoutCycles = 16, no done -> timeout_o pulse exactly 16 cycles after WAIT_DONE entry, then IDLE; repeat with matching done on cycle 16 -> no timeout pulse.
REQ-035 Reset asserted mid-WAIT_DONE -> all outputs zero asynchronously; state IDLE after release.
